// File: rtl/piece_locker_pkg.sv
// Shared definitions for the piece locker: board size defaults, FSM state
// encoding and 4x4 shape mask helpers used by the locker and the shape generator.
package piece_locker_pkg;

  localparam int DEF_BOARD_W = 10;
  localparam int DEF_BOARD_H = 20;

  // Explicit encodings keep the debug state output stable across tools.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_MERGE = 3'd2,
    ST_SCAN  = 3'd3,
    ST_ZERO  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Mask bit 4*r+c is shape row r, column c; pack four rows into a mask.
  function automatic logic [15:0] mask_encode(input logic [3:0] r0, input logic [3:0] r1,
                                              input logic [3:0] r2, input logic [3:0] r3);
    return {r3, r2, r1, r0};
  endfunction

  // Extract shape row r (bit c of the result is column c).
  function automatic logic [3:0] mask_row(input logic [15:0] mask, input logic [1:0] r);
    logic [3:0] row;
    case (r)
      2'd0:    row = mask[3:0];
      2'd1:    row = mask[7:4];
      2'd2:    row = mask[11:8];
      default: row = mask[15:12];
    endcase
    return row;
  endfunction

endpackage

// File: rtl/piece_locker_row_full_detect.sv
// Flags a board row whose every cell is occupied.
module row_full_detect
  import piece_locker_pkg::*;
#(
  parameter int W = DEF_BOARD_W
) (
  input  logic [W-1:0] row,
  output logic         full
);

  assign full = &row;

endmodule

// File: rtl/piece_locker.sv
// Piece locker: collision-checks a 4x4 piece against the board, merges it on a
// lock, then compacts away full rows with a bottom-up read/write pointer scan.
//
// Handshake: a request is taken on the rising edge where piece_valid and
// piece_ready are both high; op/mask/x/y are captured on that edge. piece_ready
// is high only in IDLE with clear_board low, and completion is a one-cycle done.
module piece_locker
  import piece_locker_pkg::*;
#(
  parameter int BOARD_W = DEF_BOARD_W,
  parameter int BOARD_H = DEF_BOARD_H
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               piece_valid,
  output logic               piece_ready,
  input  logic               piece_op,
  input  logic [15:0]        piece_mask,
  input  logic [4:0]         piece_x,
  input  logic [4:0]         piece_y,
  input  logic               clear_board,
  output logic               done,
  output logic               collide,
  output logic [2:0]         lines_cleared,
  output logic               game_over,
  input  logic [4:0]         rd_row,
  output logic [BOARD_W-1:0] rd_data,
  output logic [2:0]         state_dbg
);

  state_e             state_q, state_d;
  logic               run_q, run_d;
  logic               op_q, op_d;
  logic [15:0]        mask_q, mask_d;
  logic [4:0]         x_q, x_d, y_q, y_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               coll_q, coll_d;
  logic [5:0]         r_q, r_d, w_q, w_d;
  logic [2:0]         lines_q, lines_d;
  logic               done_q, done_d;
  logic               collide_q, collide_d;
  logic [2:0]         lines_out_q, lines_out_d;
  logic               game_over_q, game_over_d;
  logic [BOARD_W-1:0] board_q [BOARD_H];
  logic [BOARD_W-1:0] board_d [BOARD_H];

  // Per-row datapath for CHECK/MERGE
  logic [5:0]         row_idx;
  logic               row_in_range;
  logic [3:0]         cur_row;
  logic [5:0]         col_tmp;
  logic [BOARD_W-1:0] sel_row;
  logic [BOARD_W-1:0] placed;
  logic               oob;
  logic               row_coll;
  logic [BOARD_W-1:0] scan_row;
  logic               scan_full;

  assign piece_ready   = run_q && (state_q == ST_IDLE) && !clear_board;
  assign done          = done_q;
  assign collide       = collide_q;
  assign lines_cleared = lines_out_q;
  assign game_over     = game_over_q;
  assign state_dbg     = state_q;

  // Place the current mask row on the board (6-bit columns never wrap) and test it.
  always_comb begin
    row_idx      = {1'b0, y_q} + {4'b0, cnt_q};
    row_in_range = row_idx < 6'(BOARD_H);
    cur_row      = mask_row(mask_q, cnt_q);
    col_tmp      = '0;
    sel_row      = '0;
    placed       = '0;
    oob          = 1'b0;
    for (int i = 0; i < BOARD_H; i++) begin
      if (row_idx == 6'(i)) sel_row = board_q[i];
    end
    for (int c = 0; c < 4; c++) begin
      if (cur_row[c]) begin
        col_tmp = {1'b0, x_q} + 6'(c);
        if (col_tmp >= 6'(BOARD_W)) oob = 1'b1;
        for (int j = 0; j < BOARD_W; j++) begin
          if (col_tmp == 6'(j)) placed[j] = 1'b1;
        end
      end
    end
    row_coll = (|cur_row) && (!row_in_range || oob || (|(placed & sel_row)));
  end

  // Board row under the scan read pointer and the display read port.
  always_comb begin
    scan_row = '0;
    rd_data  = '0;
    for (int i = 0; i < BOARD_H; i++) begin
      if (r_q == 6'(i)) scan_row = board_q[i];
      if (rd_row == 5'(i)) rd_data = board_q[i];
    end
  end

  row_full_detect #(.W(BOARD_W)) u_row_full (
    .row  (scan_row),
    .full (scan_full)
  );

  // FSM and board next-state: at most one board row written per cycle,
  // except the bulk clears in ZERO and on clear_board.
  always_comb begin
    state_d     = state_q;
    run_d       = 1'b1;
    op_d        = op_q;
    mask_d      = mask_q;
    x_d         = x_q;
    y_d         = y_q;
    cnt_d       = cnt_q;
    coll_d      = coll_q;
    r_d         = r_q;
    w_d         = w_q;
    lines_d     = lines_q;
    done_d      = 1'b0;
    collide_d   = collide_q;
    lines_out_d = lines_out_q;
    game_over_d = game_over_q;
    board_d     = board_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_board) begin
          for (int i = 0; i < BOARD_H; i++) board_d[i] = '0;
          game_over_d = 1'b0;
        end else if (piece_valid && run_q) begin
          op_d    = piece_op;
          mask_d  = piece_mask;
          x_d     = piece_x;
          y_d     = piece_y;
          cnt_d   = 2'd0;
          coll_d  = 1'b0;
          lines_d = 3'd0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        coll_d = coll_q | row_coll;
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          if (!op_q || coll_q || row_coll) state_d = ST_DONE;
          else                             state_d = ST_MERGE;
        end
      end
      ST_MERGE: begin
        for (int i = 0; i < BOARD_H; i++) begin
          if (row_idx == 6'(i)) board_d[i] = board_q[i] | placed;
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          r_d     = 6'(BOARD_H - 1);
          w_d     = 6'(BOARD_H - 1);
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // w never passes r, so reading the old row r and writing row w is safe.
        if (scan_full) begin
          lines_d = lines_q + 3'd1;
        end else begin
          for (int i = 0; i < BOARD_H; i++) begin
            if (w_q == 6'(i)) board_d[i] = scan_row;
          end
          w_d = w_q - 6'd1;
        end
        r_d = r_q - 6'd1;
        if (r_q == 6'd0) state_d = ST_ZERO;
      end
      ST_ZERO: begin
        // An underflowed w (wrapped past 0) means every row was kept.
        for (int i = 0; i < BOARD_H; i++) begin
          if ((w_q < 6'(BOARD_H)) && (6'(i) <= w_q)) board_d[i] = '0;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d      = 1'b1;
        collide_d   = coll_q;
        lines_out_d = lines_q;
        if (op_q && coll_q) game_over_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any request and wipes the board.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      run_q       <= 1'b0;
      op_q        <= 1'b0;
      mask_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      cnt_q       <= '0;
      coll_q      <= 1'b0;
      r_q         <= '0;
      w_q         <= '0;
      lines_q     <= '0;
      done_q      <= 1'b0;
      collide_q   <= 1'b0;
      lines_out_q <= '0;
      game_over_q <= 1'b0;
      for (int i = 0; i < BOARD_H; i++) board_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      op_q        <= op_d;
      mask_q      <= mask_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cnt_q       <= cnt_d;
      coll_q      <= coll_d;
      r_q         <= r_d;
      w_q         <= w_d;
      lines_q     <= lines_d;
      done_q      <= done_d;
      collide_q   <= collide_d;
      lines_out_q <= lines_out_d;
      game_over_q <= game_over_d;
      board_q     <= board_d;
    end
  end

endmodule

// File: tb/tb_piece_locker.sv
// Self-checking bench for piece_locker: a request-level board model predicts
// completion cycle, results and board contents; a per-cycle compare process
// checks the DUT against it, plus directed literal checks.
module tb_piece_locker;
  import piece_locker_pkg::*;

  localparam int W = 10;
  localparam int H = 20;

  logic         clk, reset;
  logic         piece_valid, piece_ready, piece_op, clear_board;
  logic [15:0]  piece_mask;
  logic [4:0]   piece_x, piece_y, rd_row;
  logic         done, collide, game_over;
  logic [2:0]   lines_cleared, state_dbg;
  logic [W-1:0] rd_data;

  int n_cmp = 0;
  int n_bad = 0;

  piece_locker #(.BOARD_W(W), .BOARD_H(H)) dut (
    .clk(clk), .reset(reset), .piece_valid(piece_valid), .piece_ready(piece_ready),
    .piece_op(piece_op), .piece_mask(piece_mask), .piece_x(piece_x), .piece_y(piece_y),
    .clear_board(clear_board), .done(done), .collide(collide),
    .lines_cleared(lines_cleared), .game_over(game_over), .rd_row(rd_row),
    .rd_data(rd_data), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  logic [W-1:0] mb [H];
  logic [3:0]   exp_q [$];
  bit           busy, run, acc_now, exp_done, exp_col, exp_go, pend_op, chk_en;
  logic [2:0]   exp_lines;
  int           cyc, acc_cyc, done_cyc;
  logic [3:0]   pop_v;
  bit           m_col;
  logic [2:0]   m_lines;

  logic [15:0] shapes [7] = '{16'h000F, 16'h0033, 16'h0027, 16'h0036,
                              16'h0063, 16'h0017, 16'h0071};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  // Whole-request model: collision, merge, full-row removal keeping row order.
  task automatic model_request(input bit op, input logic [15:0] m, input int x, input int y,
                               output bit col, output logic [2:0] lines);
    logic [W-1:0] keep [$];
    col   = 1'b0;
    lines = 3'd0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (m[4*r+c]) begin
          int rr = y + r;
          int cc = x + c;
          if (cc >= W || rr >= H) col = 1'b1;
          else if (mb[rr][cc])     col = 1'b1;
        end
    if (op && !col) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (m[4*r+c]) mb[y+r][x+c] = 1'b1;
      for (int r = H - 1; r >= 0; r--) begin
        if (mb[r] == {W{1'b1}}) lines = lines + 3'd1;
        else                    keep.push_back(mb[r]);
      end
      for (int r = H - 1; r >= 0; r--) begin
        int idx = H - 1 - r;
        mb[r] = (idx < keep.size()) ? keep[idx] : '0;
      end
    end
  endtask

  // Model update on each edge: completion, board clear or acceptance.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy = 0; run = 0; acc_now = 0; exp_done = 0; exp_col = 0; exp_go = 0;
      exp_lines = 3'd0;
      exp_q.delete();
      for (int i = 0; i < H; i++) mb[i] = '0;
    end else begin
      cyc++;
      acc_now  = 0;
      exp_done = 0;
      if (busy) begin
        if (cyc == done_cyc) begin
          exp_done = 1;
          busy     = 0;
          if (exp_q.size() > 0) begin
            pop_v     = exp_q.pop_front();
            exp_col   = pop_v[3];
            exp_lines = pop_v[2:0];
            if (pend_op && exp_col) exp_go = 1;
          end
        end
      end else if (clear_board) begin
        for (int i = 0; i < H; i++) mb[i] = '0;
        exp_go = 0;
      end else if (piece_valid && run) begin
        model_request(piece_op, piece_mask, int'(piece_x), int'(piece_y), m_col, m_lines);
        exp_q.push_back({m_col, m_lines});
        pend_op  = piece_op;
        busy     = 1;
        acc_now  = 1;
        acc_cyc  = cyc;
        done_cyc = cyc + ((piece_op && !m_col) ? (10 + H) : 5);
      end
      run = 1;
    end
  end

  // Per-cycle compare of all handshake and result outputs.
  always @(posedge clk) begin
    #1;
    if (reset && chk_en) begin
      check("done", done, exp_done);
      check("ready", piece_ready, run && !busy && !clear_board);
      check("collide", collide, exp_col);
      check("lines", lines_cleared, exp_lines);
      check("game_over", game_over, exp_go);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sweep(input string tag);
    for (int i = 0; i < H + 2; i++) begin
      rd_row = 5'(i);
      #1;
      check(tag, rd_data, (i < H) ? mb[i] : '0);
    end
  endtask

  task automatic present(input bit op, input logic [15:0] m, input int x, input int y);
    bit ok = 0;
    @(negedge clk);
    piece_valid = 1; piece_op = op; piece_mask = m; piece_x = 5'(x); piece_y = 5'(y);
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #2;
      if (acc_now) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: actual=none required=accept @%0t", $time);
    end
    @(negedge clk);
    piece_valid = 0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #2;
      if (done === 1'b1) begin lat = cyc - acc_cyc; break; end
    end
    if (lat < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: actual=no_done required=done @%0t", $time);
    end
    for (int k = 0; k < 100 && busy; k++) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic send(input bit op, input logic [15:0] m, input int x, input int y, output int lat);
    present(op, m, x, y);
    wait_done(lat);
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear_board = 1;
    @(negedge clk); clear_board = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    reset = 0; piece_valid = 0; piece_op = 0; piece_mask = '0; piece_x = '0; piece_y = '0;
    clear_board = 0; rd_row = '0; chk_en = 0; cyc = 0;

    // Reset state while reset is held low
    #12;
    check("rst_done", done, 0);
    check("rst_collide", collide, 0);
    check("rst_lines", lines_cleared, 0);
    check("rst_game_over", game_over, 0);
    check("rst_ready", piece_ready, 0);
    sweep("rst_board");
    @(negedge clk); reset = 1; chk_en = 1;

    // Probe of a flat I on the bottom row of an empty board
    send(0, 16'h000F, 0, 19, lat);
    check("probe_latency", lat, 5);
    check("probe_collide", collide, 0);
    sweep("probe_board");

    // Probe sticking out past the right edge
    send(0, 16'h000F, 7, 19, lat);
    check("edge_collide", collide, 1);
    check("edge_game_over", game_over, 0);

    // Fill rows 16..19 except column 9, then drop a vertical I into the well
    for (int r = 16; r < 20; r++) begin
      send(1, 16'h000F, 0, r, lat);
      check("fill_latency", lat, 10 + H);
      send(1, 16'h000F, 4, r, lat);
      send(1, 16'h0001, 8, r, lat);
    end
    rd_row = 5'd19; #1;
    check("well_row19", rd_data, 10'h1FF);
    send(1, 16'h1111, 9, 16, lat);
    check("tetris_latency", lat, 30);
    check("tetris_lines", lines_cleared, 4);
    check("tetris_model_lines", exp_lines, 4);
    rd_row = 5'd19; #1;
    check("tetris_row19", rd_data, 0);
    sweep("tetris_board");

    // Overlapping lock: collide, game over, board untouched; clear resets game over
    send(1, 16'h0033, 3, 10, lat);
    send(1, 16'h0033, 4, 10, lat);
    check("overlap_collide", collide, 1);
    check("overlap_game_over", game_over, 1);
    rd_row = 5'd10; #1;
    check("overlap_row10", rd_data, 10'h018);
    sweep("overlap_board");
    pulse_clear();
    @(posedge clk); #2;
    check("clear_game_over", game_over, 0);
    sweep("clear_board");

    // Reset in the middle of the row scan
    present(1, 16'h000F, 0, 19);
    repeat (14) @(posedge clk);
    @(negedge clk); reset = 0;
    #1;
    check("midrst_done", done, 0);
    check("midrst_collide", collide, 0);
    check("midrst_lines", lines_cleared, 0);
    check("midrst_game_over", game_over, 0);
    check("midrst_ready", piece_ready, 0);
    sweep("midrst_board");
    @(negedge clk); reset = 1;
    #1;
    check("release_ready_before_edge", piece_ready, 0);
    @(posedge clk); #2;
    check("release_ready_after_edge", piece_ready, 1);

    // Randomized requests against the model
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 99) < 5) begin
        pulse_clear();
      end else begin
        bit          op = ($urandom_range(0, 9) < 7);
        logic [15:0] m  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : shapes[$urandom_range(0, 6)];
        int          x  = $urandom_range(0, W - 1);
        int          y  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, H - 1)
                                                      : $urandom_range(H - 6, H - 1);
        send(op, m, x, y, lat);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (it % 10 == 0) sweep("rand_board");
    end

    // clear_board beats a simultaneous request; the request goes in next cycle
    pulse_clear();
    send(1, 16'h0033, 0, 18, lat);
    @(negedge clk);
    clear_board = 1; piece_valid = 1; piece_op = 0; piece_mask = 16'h000F;
    piece_x = 5'd0; piece_y = 5'd19;
    @(posedge clk); #2;
    check("both_ready_low", piece_ready, 0);
    check("both_model_no_accept", acc_now, 0);
    @(negedge clk); clear_board = 0;
    @(posedge clk); #2;
    check("both_model_accept", acc_now, 1);
    @(negedge clk); piece_valid = 0;
    wait_done(lat);
    check("both_latency", lat, 5);
    rd_row = 5'd18; #1;
    check("both_row18", rd_data, 0);
    sweep("both_board");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global bound on the run
  initial begin
    #1000000;
    n_bad++;
    $display("FAIL global_timeout: actual=running required=finished @%0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/piece_locker.md
PIECE_LOCKER -- requirements
Module: piece_locker

Interface
REQ-001 Parameter BOARD_W, default 10: board width in columns (4..16).
REQ-002 Parameter BOARD_H, default 20: board height in rows (4..31); row 0 is the top row.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 piece_valid  input  1  active piece presented.
REQ-006 piece_ready  output  1  block in IDLE, able to accept a piece.
REQ-007 piece_op  input  1  0 = probe (collision check only), 1 = lock (check, merge, clear lines).
REQ-008 piece_mask  input  16  4x4 shape; bit 4*r+c is piece row r, column c.
REQ-009 piece_x  input  5  board column of mask column 0, unsigned.
REQ-010 piece_y  input  5  board row of mask row 0, unsigned.
REQ-011 clear_board  input  1  zero the whole board and game_over; honoured only in IDLE.
REQ-012 done  output  1  one-cycle pulse when an accepted request completes.
REQ-013 collide  output  1  result of the last request, valid from done until the next done.
REQ-014 lines_cleared  output  3  full rows removed by the last lock (0..4).
REQ-015 game_over  output  1  sticky; set when a lock request collides.
REQ-016 rd_row  input  5  display read address.
REQ-017 rd_data  output  BOARD_W  board row rd_row, combinational; zero if rd_row >= BOARD_H.

Function
REQ-018 Handshake: acceptance is on the edge where piece_valid and piece_ready are both 1; mask, x, y and op are captured at that edge.
REQ-019 FSM states: IDLE, CHECK, MERGE, SCAN, ZERO, DONE.
REQ-020 CHECK: 4 cycles, one mask row per cycle, and ORs collisions into a sticky flag.
REQ-021 Collision definition: a set mask cell that overlaps an occupied board cell, or that lies at column >= BOARD_W or row >= BOARD_H.
REQ-022 After CHECK, the next state is:
- probe -> DONE;
- lock with collision -> DONE, with game_over set and the board unchanged;
- lock without collision -> MERGE.
REQ-023 MERGE: 4 cycles, ORs each mask row into the board row, then -> SCAN.
REQ-024 SCAN: one cycle per row, with read pointer r and write pointer w both starting at BOARD_H-1.
- Full row r: skipped and lines_cleared incremented.
- Otherwise: row r is copied to row w and w is decremented.
- r decrements each cycle; after r = 0 -> ZERO.
REQ-025 ZERO: one cycle; rows 0..w are cleared when w was not underflowed; -> DONE.
REQ-026 DONE: one cycle; done = 1, collide and lines_cleared are updated; -> IDLE.
REQ-027 Latency from the acceptance edge to the done cycle:
- probe or colliding lock: 5 cycles;
- successful lock: 9 + BOARD_H + 1 cycles (30 at default).
REQ-028 piece_ready = 1 only in IDLE with clear_board = 0, so clear_board beats simultaneous piece_valid.
REQ-029 clear_board in IDLE zeroes the board and game_over in one cycle; clear_board is ignored in all other states.
REQ-030 Locks are still accepted while game_over = 1; game_over has no other effect on operation.
REQ-031 Index arithmetic is done at 6 bits so that piece_x + c and piece_y + r do not wrap.

Reset
REQ-032 Asynchronous assertion (reset = 0) forces all of the following immediately, including mid-operation:
- state IDLE;
- board all zero;
- done, collide, game_over = 0;
- lines_cleared = 0.
REQ-033 piece_ready rises on the first edge after reset deasserts; any request in flight is discarded.

Structure
REQ-034 A shared package holds:
- the state enum;
- the 16-bit mask encoding helper;
- BOARD_W and BOARD_H defaults, shared with the active-shape generator.
REQ-035 A single sub-module, row_full_detect, is natural: combinational AND-reduce of one row.
REQ-036 Board storage is a register array of BOARD_H x BOARD_W bits (no RAM), with one write row per cycle except in ZERO and clear_board.

Verification
REQ-037 Empty board, probe with mask 0x000F, x=0, y=19 -> done 5 cycles after accept, collide=0, board unchanged.
REQ-038 Probe with mask 0x000F, x=7 -> collide=1, because columns 10 exceed BOARD_W; game_over stays 0.
REQ-039 Rows 16..19 all full except column 9; lock vertical I (mask 0x1111) at x=9, y=16 -> done at cycle 30, lines_cleared=4, board empty.
REQ-040 Lock of an overlapping piece -> collide=1, game_over=1, board bit-identical to before; then clear_board -> game_over=0.
REQ-041 Assert reset during SCAN -> board zero and outputs at reset values immediately; piece_ready=1 one edge after release.
REQ-042 clear_board and piece_valid asserted in the same IDLE cycle -> no acceptance, board cleared; the piece is accepted the next cycle.
